mem_scan_reader: RTL and testbench
==================================

# mem_scan_reader

Read-side initiator for one port of the shared dual-port data memory. On a `start` pulse it sweeps a fixed contiguous window of memory words, for example the Tron game grid, and drives each word onto a valid/ready stream for downstream consumers such as the renderer or the collision checker. It absorbs the memory's one-cycle registered-address read latency. It sustains one word per cycle when the consumer never stalls.

## Interface
Parameters:
- `DATA_WIDTH`, 16, memory word width.
- `ADDR_WIDTH`, 10, memory address width.
- `BASE_ADDR`, 10'h200, first word address of the window.
- `LENGTH`, 256, number of words per sweep; range 1..2**ADDR_WIDTH.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until the sweep finishes.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `mem_addr`  out  ADDR_WIDTH  read address, registered; connects to the memory port address.
- `mem_we`  out  1  constant 0.
- `mem_rdata`  in  DATA_WIDTH  memory port data out; valid the cycle after `mem_addr` is sampled.
- `out_data`  out  DATA_WIDTH  word being presented.
- `out_index`  out  ADDR_WIDTH  offset of the word within the window (0..LENGTH-1).
- `out_last`  out  1  high with the word at offset LENGTH-1.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready; a transfer happens on a cycle with valid && ready.

## Operation
- States:
  - IDLE: waits for `start`; `start` moves the block to SCAN.
  - SCAN: issues reads; after issuing offset LENGTH-1 it moves to DRAIN.
  - DRAIN: waits for the transfer of offset LENGTH-1, then returns to IDLE.
- Issue: a read is issued in a cycle when the state is SCAN and `occ + inflight - pop <= 1`.
  - `occ` is the buffer occupancy (0..2).
  - `inflight` is set when a read was issued in the previous cycle.
  - `pop` is the output transfer in the current cycle.
- Each issue increments the issue counter, and `mem_addr` advances to `BASE_ADDR + counter`, computed modulo 2**ADDR_WIDTH. A window that crosses the top of memory wraps to address 0.
- Capture: when `inflight`=1, `mem_rdata` is pushed into a 2-entry buffer together with its offset. Data arriving when `inflight`=0 is ignored.
- The buffer never overflows. This follows from the issue rule; the verification engineer asserts it.
- Output: the buffer head drives `out_*`. `out_valid` is high whenever `occ` > 0.
- Push and pop in the same cycle are both legal.
- While `out_valid`=1 and `out_ready`=0, `out_*` stay stable.
- `start` outside IDLE is ignored. The sweep is not restartable.
- Reset takes effect from any state, mid-sweep included:
  - state returns to IDLE;
  - the buffer is flushed and `inflight` is cleared;
  - no partial `done` is produced.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `out_index`=0, `mem_addr`=BASE_ADDR, `mem_we`=0.

## Timing
Cycle numbering below counts from cycle 0, the cycle in which `start` is high and the state is IDLE.
- Cycle 1: `busy`=1 and `mem_addr`=BASE_ADDR. Offset 0 is issued.
- Cycle 2: `mem_rdata` holds the word at BASE_ADDR.
- Cycle 3: the first `out_valid`=1.
- With `out_ready` held at 1, one word transfers per cycle in cycles 3..LENGTH+2. `done`=1 and `busy`=0 in cycle LENGTH+3.
- On the edge that transfers `out_last`, the state becomes IDLE. In the next cycle, `done`=1, `busy`=0, and a new `start` is accepted.
- Back-pressure: a stall of N cycles delays all later words by exactly N cycles and creates no gaps beyond N.
  - At most 2 words are buffered plus 0 in flight, or 1 buffered plus 1 in flight.
  - When ready returns, words resume back-to-back.
- LENGTH=1: issue in cycle 1, valid from cycle 3 with `out_last`=1. Back-to-back sweeps are legal.

## Structure
- A shared package (`mem_pkg`) holds:
  - the state encoding (IDLE, SCAN, DRAIN);
  - `MEM_READ_LATENCY`=1;
  - the default DATA_WIDTH/ADDR_WIDTH constants used by the memory block and by this block.
- One sub-module: `fifo2`, a 2-entry synchronous FIFO with push, pop and count outputs. It has the same clock and reset and is parameterised by width (DATA_WIDTH+ADDR_WIDTH+1).
- The top level holds the FSM, the issue counter, the `inflight` flag and the issue rule.

## Test plan
- Smoke:
  - Stimulus: preload mem[0x200+i]=i*3, LENGTH=4, `out_ready`=1, `start` pulsed in cycle 0.
  - Response: data 0,3,6,9 in cycles 3–6, `out_last` only in cycle 6, `done` in cycle 7 only.
- Back-pressure:
  - Stimulus: LENGTH=8, `out_ready` low in cycles 4–7.
  - Response: `out_data` is stable during the stall, no word is dropped or duplicated, the sequence is in order, and `done` is 4 cycles later than the unstalled run.
- Wrap-around:
  - Stimulus: BASE_ADDR=0x3FE, LENGTH=4.
  - Response: `mem_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001; `out_index` 0..3.
- Reset mid-sweep:
  - Stimulus: assert `reset` for one cycle when `out_index`=2.
  - Response: next cycle `out_valid`=0, `busy`=0, `mem_addr`=BASE_ADDR, and no `done`. A new `start` then yields a full sweep from offset 0.
- Start handling:
  - Stimulus: `start` held high during SCAN, then pulsed in the `done` cycle.
  - Response: the first sweep is unaffected, and the second sweep begins with `busy`=1 in the following cycle.
- Random:
  - Stimulus: random `out_ready` over 1000 sweeps with LENGTH=1.
  - Response: every sweep delivers exactly one word with `out_last`=1 followed by one `done`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port and its read-side scanner.
package mem_pkg;

  localparam int unsigned MEM_DATA_WIDTH   = 16;
  localparam int unsigned MEM_ADDR_WIDTH   = 10;
  localparam int unsigned MEM_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2
  } scan_state_e;

endpackage

// File: rtl/mem_scan_reader_if.sv
// Control, memory read port and output stream of the window scanner.
interface mem_scan_reader_if import mem_pkg::*; #(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) ();

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start,
    output busy,
    output done,
    output mem_addr,
    output mem_we,
    input  mem_rdata,
    output out_data,
    output out_index,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  mem_addr,
    input  mem_we,
    output mem_rdata,
    input  out_data,
    input  out_index,
    input  out_last,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mem_scan_reader_fifo2.sv
// Two-entry synchronous FIFO; entry 0 is always the head so the output is a plain register.
module fifo2 #(
  parameter int unsigned WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic [1:0]       count_q, count_d;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        data_d[count_q[0]] = wdata_i;
        count_d            = count_q + 2'd1;
      end
      2'b01: begin
        data_d[0] = data_q[1];
        count_d   = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          data_d[0] = data_q[1];
          data_d[1] = wdata_i;
        end else begin
          data_d[0] = wdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      count_q   <= 2'd0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = data_q[0];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !pop_i && count_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/mem_scan_reader.sv
// Sweeps a fixed memory window on start and streams each word out, absorbing the
// one-cycle registered read latency with a 2-entry skid buffer.
module mem_scan_reader import mem_pkg::*; #(
  parameter int unsigned           DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h200,
  parameter int unsigned           LENGTH     = 256
) (
  input  logic               clk,
  input  logic               reset,
  mem_scan_reader_if.master  bus
);

  localparam int unsigned     CntW    = ADDR_WIDTH + 1;
  localparam int unsigned     EntryW  = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] LastOff = CntW'(LENGTH - 1);

  scan_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
  logic                  infl_last_q, infl_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [1:0]        occ;
  logic [EntryW-1:0] head;
  logic              head_last;
  logic              out_valid;
  logic              pop;
  logic              issue;
  logic [2:0]        occ_after;

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign head_last = head[EntryW-1];

  // Issue only if the word it returns is guaranteed a buffer slot next cycle.
  assign occ_after = {1'b0, occ} + {2'b00, inflight_q};
  assign issue     = (state_q == StScan) && (occ_after <= 3'd1 + {2'b00, pop});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    infl_idx_d  = infl_idx_q;
    infl_last_d = infl_last_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StScan;
          cnt_d   = '0;
          addr_d  = BASE_ADDR;
        end
      end
      StScan: begin
        if (issue) begin
          cnt_d       = cnt_q + 1'b1;
          addr_d      = BASE_ADDR + cnt_d[ADDR_WIDTH-1:0];
          infl_idx_d  = cnt_q[ADDR_WIDTH-1:0];
          infl_last_d = (cnt_q == LastOff);
          if (cnt_q == LastOff) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_q == StDrain) && pop && head_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= BASE_ADDR;
      inflight_q  <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      inflight_q  <= issue;
      infl_idx_q  <= infl_idx_d;
      infl_last_q <= infl_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  fifo2 #(
    .WIDTH (EntryW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .wdata_i ({infl_last_q, infl_idx_q, bus.mem_rdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (occ)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = 1'b0;
  assign bus.out_data  = head[DATA_WIDTH-1:0];
  assign bus.out_index = head[DATA_WIDTH +: ADDR_WIDTH];
  assign bus.out_last  = head_last;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed bench for mem_scan_reader: four instances cover smoke, stall, wrap and LENGTH=1.
module tb_mem_scan_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [1024];

  mem_scan_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) if_a ();
  mem_scan_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) if_b ();
  mem_scan_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) if_c ();
  mem_scan_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) if_d ();

  mem_scan_reader #(.BASE_ADDR(10'h200), .LENGTH(4)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  mem_scan_reader #(.BASE_ADDR(10'h200), .LENGTH(8)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  mem_scan_reader #(.BASE_ADDR(10'h3FE), .LENGTH(4)) u_c (.clk(clk), .reset(reset), .bus(if_c));
  mem_scan_reader #(.BASE_ADDR(10'h200), .LENGTH(1)) u_d (.clk(clk), .reset(reset), .bus(if_d));

  // One-cycle registered-address read ports.
  always @(posedge clk) if_a.mem_rdata <= mem[if_a.mem_addr];
  always @(posedge clk) if_b.mem_rdata <= mem[if_b.mem_addr];
  always @(posedge clk) if_c.mem_rdata <= mem[if_c.mem_addr];
  always @(posedge clk) if_d.mem_rdata <= mem[if_d.mem_addr];

  function automatic logic [15:0] word_at(input int a);
    return 16'(((a - 512) * 3) & 32'hFFFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in cycle 0 with if_a.start already high; returns in cycle 7 (the done cycle).
  task automatic a_sweep(input bit hold);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if_a.start = hold && (c <= 5);
      check("a_busy", 32'(if_a.busy), 32'(c <= 6));
      check("a_done", 32'(if_a.done), 32'(c == 7));
      check("a_valid", 32'(if_a.out_valid), 32'(c >= 3 && c <= 6));
      if (c == 1) check("a_addr_first", 32'(if_a.mem_addr), 32'h200);
      if (c >= 3 && c <= 6) begin
        check("a_data", 32'(if_a.out_data), 32'(word_at(32'h200 + c - 3)));
        check("a_index", 32'(if_a.out_index), 32'(c - 3));
        check("a_last", 32'(if_a.out_last), 32'(c == 6));
      end
    end
  endtask

  initial begin
    int idx;
    int words;
    int lasts;
    bit got_done;

    for (int a = 0; a < 1024; a++) mem[a] = word_at(a);
    if_a.start = 1'b0; if_a.out_ready = 1'b1;
    if_b.start = 1'b0; if_b.out_ready = 1'b1;
    if_c.start = 1'b0; if_c.out_ready = 1'b1;
    if_d.start = 1'b0; if_d.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(if_a.busy), 32'd0);
    check("rst_done", 32'(if_a.done), 32'd0);
    check("rst_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_last", 32'(if_a.out_last), 32'd0);
    check("rst_data", 32'(if_a.out_data), 32'd0);
    check("rst_index", 32'(if_a.out_index), 32'd0);
    check("rst_addr", 32'(if_a.mem_addr), 32'h200);
    check("rst_we", 32'(if_a.mem_we), 32'd0);
    check("rst_addr_wrap", 32'(if_c.mem_addr), 32'h3FE);
    reset = 1'b0;
    tick();

    // Smoke
    if_a.start = 1'b1;
    a_sweep(1'b0);
    tick();
    check("smoke_done_pulse", 32'(if_a.done), 32'd0);

    // Reset mid-sweep when offset 2 is presented (cycle 5)
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    repeat (4) tick();
    check("rstmid_index", 32'(if_a.out_index), 32'd2);
    check("rstmid_valid_before", 32'(if_a.out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_valid", 32'(if_a.out_valid), 32'd0);
    check("rstmid_busy", 32'(if_a.busy), 32'd0);
    check("rstmid_addr", 32'(if_a.mem_addr), 32'h200);
    check("rstmid_done", 32'(if_a.done), 32'd0);
    tick();
    check("rstmid_done_late", 32'(if_a.done), 32'd0);
    if_a.start = 1'b1;
    a_sweep(1'b0);
    tick();

    // Start held during the sweep, then pulsed in the done cycle
    if_a.start = 1'b1;
    a_sweep(1'b1);
    if_a.start = 1'b1;
    a_sweep(1'b0);
    tick();

    // Back-pressure: ready low in cycles 4..7
    if_b.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if_b.start = 1'b0;
      if_b.out_ready = !(c >= 4 && c <= 7);
      idx = (c == 3) ? 0 : ((c <= 7) ? 1 : c - 7);
      check("bp_valid", 32'(if_b.out_valid), 32'(c >= 3 && c <= 14));
      check("bp_done", 32'(if_b.done), 32'(c == 15));
      check("bp_busy", 32'(if_b.busy), 32'(c <= 14));
      if (c >= 3 && c <= 14) begin
        check("bp_data", 32'(if_b.out_data), 32'(word_at(32'h200 + idx)));
        check("bp_index", 32'(if_b.out_index), 32'(idx));
        check("bp_last", 32'(if_b.out_last), 32'(idx == 7));
      end
    end
    if_b.out_ready = 1'b1;
    tick();

    // Wrap-around window 0x3FE..0x001
    if_c.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if_c.start = 1'b0;
      if (c <= 4) check("wrap_addr", 32'(if_c.mem_addr), (32'h3FE + c - 1) & 32'h3FF);
      if (c >= 3 && c <= 6) begin
        check("wrap_index", 32'(if_c.out_index), 32'(c - 3));
        check("wrap_data", 32'(if_c.out_data), 32'(word_at((32'h3FE + c - 3) & 32'h3FF)));
      end
      check("wrap_done", 32'(if_c.done), 32'(c == 7));
    end
    tick();

    // LENGTH=1 sweeps back to back under random ready
    if_d.start = 1'b1;
    for (int s = 0; s < 1000; s++) begin
      words = 0;
      lasts = 0;
      got_done = 1'b0;
      tick();
      if_d.start = 1'b0;
      check("rnd_busy", 32'(if_d.busy), 32'd1);
      check("rnd_done_pulse", 32'(if_d.done), 32'd0);
      for (int k = 0; k < 100 && !got_done; k++) begin
        if_d.out_ready = 1'($urandom_range(0, 1));
        if (if_d.out_valid && if_d.out_ready) begin
          words++;
          if (if_d.out_last) lasts++;
        end
        tick();
        if (if_d.done) got_done = 1'b1;
      end
      check("rnd_done_seen", 32'(got_done), 32'd1);
      check("rnd_words", 32'(words), 32'd1);
      check("rnd_lasts", 32'(lasts), 32'd1);
      if (s < 999) if_d.start = 1'b1;
    end
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
